// File: rtl/clock_div_prog.sv
// Runtime-programmable 50%-duty clock divider for even and odd divisors.
// Divisor changes and start/stop take effect only on period boundaries, so clock_out never glitches.
module clock_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_ack,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             period_tick,
    output logic             active
);
    // state | meaning
    // IDLE  | stopped, clock_out low, pending divisor held until next start
    // RUN   | counting periods of cur_div cycles, cnt = 0 .. cur_div-1
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] pend_div;
    logic             pend_valid;
    logic             pos_q;
    logic             neg_q;

    logic             ld_ok;
    logic             ld_bad;
    logic             at_boundary;
    logic             apply_now;
    logic [WIDTH-1:0] next_div;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cur_hi;

    assign ld_ok       = div_load && (div_value >= WIDTH'(2));
    assign ld_bad      = div_load && (div_value <  WIDTH'(2));
    assign at_boundary = (state == RUN) && (cnt == cur_div - WIDTH'(1));
    // A load landing on the apply edge wins over the older pending value.
    assign apply_now   = enable && ((state == IDLE) || at_boundary) && (ld_ok || pend_valid);
    assign next_div    = ld_ok ? div_value : pend_div;
    assign cnt_inc     = cnt + WIDTH'(1);
    assign cur_hi      = (cur_div >> 1) + {{(WIDTH-1){1'b0}}, cur_div[0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_div    <= WIDTH'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            pos_q      <= 1'b0;
            div_ack    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (ld_bad) begin
                cfg_err <= 1'b1;
            end else if (ld_ok) begin
                cfg_err <= 1'b0;
            end

            if (apply_now) begin
                cur_div    <= next_div;
                pend_valid <= 1'b0;
                div_ack    <= 1'b1;
            end else if (ld_ok) begin
                pend_div   <= div_value;
                pend_valid <= 1'b1;
            end

            if (state == IDLE) begin
                cnt <= '0;
                if (enable) begin
                    state <= RUN;
                    pos_q <= 1'b1;
                end else begin
                    pos_q <= 1'b0;
                end
            end else if (at_boundary) begin
                cnt <= '0;
                if (enable) begin
                    pos_q <= 1'b1;
                end else begin
                    state <= IDLE;
                    pos_q <= 1'b0;
                end
            end else begin
                cnt   <= cnt_inc;
                pos_q <= (cnt_inc < cur_hi);
            end
        end
    end

    // Half-cycle delayed copy; ANDed with pos_q it trims odd periods to 50% duty.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clock_out   = cur_div[0] ? (pos_q & neg_q) : pos_q;
    assign active      = (state == RUN);
    assign period_tick = (state == RUN) && (cnt == '0);

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed steps plus random loads/enables against a period-level model.
// The model describes each period as 2N half-cycle slots and predicts which slots are high.
module tb_clock_div_prog;
    localparam int WIDTH   = 16;
    localparam int DEF_DIV = 500;

    logic             clock     = 1'b0;
    logic             reset     = 1'b0;
    logic             enable    = 1'b0;
    logic             div_load  = 1'b0;
    logic [WIDTH-1:0] div_value = '0;
    logic             div_ack;
    logic             cfg_err;
    logic             clock_out;
    logic             period_tick;
    logic             active;

    int n_assert = 0;
    int n_fail   = 0;

    bit m_act;
    int m_phase;
    int m_div;
    int m_pend;
    bit m_pend_v;
    bit m_err;
    bit m_ack;

    clock_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .div_value   (div_value),
        .div_load    (div_load),
        .div_ack     (div_ack),
        .cfg_err     (cfg_err),
        .clock_out   (clock_out),
        .period_tick (period_tick),
        .active      (active)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act    = 1'b0;
        m_phase  = 0;
        m_div    = DEF_DIV;
        m_pend   = 0;
        m_pend_v = 1'b0;
        m_err    = 1'b0;
        m_ack    = 1'b0;
    endfunction

    // Even N: slots [0, N) high.  Odd N: slots [1, N] high (rises half a cycle late).
    function automatic logic exp_clk(input int h);
        if (!m_act) return 1'b0;
        if (m_div % 2 == 1) return (h >= 1) && (h <= m_div);
        return h < m_div;
    endfunction

    function automatic void model_edge(input bit en, input bit ld, input int val);
        bit ok;
        ok    = ld && (val >= 2);
        m_ack = 1'b0;
        if (ld && val < 2) m_err = 1'b1;
        else if (ok)       m_err = 1'b0;
        if (m_act && m_phase != m_div - 1) begin
            m_phase++;
            if (ok) begin m_pend = val; m_pend_v = 1'b1; end
        end else if (en) begin
            if (ok) begin
                m_div = val; m_pend_v = 1'b0; m_ack = 1'b1;
            end else if (m_pend_v) begin
                m_div = m_pend; m_pend_v = 1'b0; m_ack = 1'b1;
            end
            m_act   = 1'b1;
            m_phase = 0;
        end else begin
            m_act   = 1'b0;
            m_phase = 0;
            if (ok) begin m_pend = val; m_pend_v = 1'b1; end
        end
    endfunction

    task automatic step(input bit en, input bit ld, input int val);
        enable    = en;
        div_load  = ld;
        div_value = val[WIDTH-1:0];
        @(posedge clock);
        model_edge(en, ld, val);
        #1;
        chk("active", active, m_act);
        chk("period_tick", period_tick, m_act && (m_phase == 0));
        chk("div_ack", div_ack, m_ack);
        chk("cfg_err", cfg_err, m_err);
        chk("clk_first_half", clock_out, exp_clk(2 * m_phase));
        @(negedge clock);
        #1;
        div_load = 1'b0;
        chk("clk_second_half", clock_out, exp_clk(2 * m_phase + 1));
    endtask

    task automatic run(input bit en, input int n);
        repeat (n) step(en, 1'b0, 0);
    endtask

    task automatic sync_to(input int div, input int phase);
        int k;
        k = 0;
        while (!(m_act && m_div == div && m_phase == phase) && k < 64) begin
            step(1'b1, 1'b0, 0);
            k++;
        end
        if (k >= 64) begin
            n_fail++;
            $error("FAIL sync_timeout: div %0d phase %0d not reached", div, phase);
        end
    endtask

    initial begin
        bit en_r;
        model_reset();
        #2;
        chk("rst_active", active, 1'b0);
        chk("rst_clock_out", clock_out, 1'b0);
        chk("rst_period_tick", period_tick, 1'b0);
        chk("rst_div_ack", div_ack, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        @(negedge clock);
        #1;
        reset = 1'b1;

        // Load 4 while idle, then start: ack on first RUN cycle, 2 high / 2 low.
        step(1'b0, 1'b1, 4);
        run(1'b0, 2);
        run(1'b1, 12);

        // Odd divisor 5: 2.5 high / 2.5 low.
        step(1'b1, 1'b1, 5);
        run(1'b1, 15);

        // At div 4, load 7 at cnt=1: current period completes, then 7.
        step(1'b1, 1'b1, 4);
        sync_to(4, 1);
        step(1'b1, 1'b1, 7);
        run(1'b1, 20);

        // Illegal loads set cfg_err and leave the waveform alone; a legal one clears it.
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 0);
        run(1'b1, 10);
        step(1'b1, 1'b1, 6);
        run(1'b1, 14);

        // Drop enable at cnt=1 of a div-8 period, then restart.
        step(1'b1, 1'b1, 8);
        sync_to(8, 1);
        run(1'b0, 12);
        run(1'b1, 10);

        // Random loads (including illegal values) and enable toggles.
        en_r = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 9)));
        end

        // Reset during a high phase drops clock_out at once and restores the default divisor.
        step(1'b1, 1'b1, 6);
        sync_to(6, 1);
        reset = 1'b0;
        #1;
        chk("midrst_clock_out", clock_out, 1'b0);
        chk("midrst_active", active, 1'b0);
        chk("midrst_period_tick", period_tick, 1'b0);
        chk("midrst_cfg_err", cfg_err, 1'b0);
        model_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        run(1'b0, 3);
        run(1'b1, 505);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
